pipeline_hazard_ctrl: RTL and testbench

- Sequences the 4-stage microcoded pipeline (s0 issue/operand, s1 ALU/branch, s2 memory, s3 writeback).
- Keeps a scoreboard of in-flight destination registers and stalls s0 on RAW hazards flagged by the s0 check_rs1_dep/check_rs2_dep microcode bits.
- Flushes s0 on a taken branch resolved in s1.
- Arbitrates the single memory port between instruction fetch and the s2 data access (mem_in_use).

---
 rtl/pipeline_pkg.sv | 28 ++
 rtl/hazard_scoreboard_cmp.sv | 39 +++
 rtl/pipeline_hazard_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
//   Shared types and constants for the 4-stage microcoded pipeline hazard
//   controller (s0 issue/operand, s1 ALU/branch, s2 memory, s3 writeback).
//
//   REG_ADDR_W       register index width
//   UC_*_BIT         bit positions of the microcode fields the controller
//                    consumes (the decoder slices them out of the s0 word)
//   stage_ctl_t      per-stage shadow entry: valid, write-enable, memory
//                    use and destination register
// ---------------------------------------------------------------------------
package pipeline_pkg;

    localparam int REG_ADDR_W = 5;

    localparam int UC_CHECK_RS1_BIT  = 0;
    localparam int UC_CHECK_RS2_BIT  = 1;
    localparam int UC_MEM_IN_USE_BIT = 11;
    localparam int UC_REG_WRITE_BIT  = 20;

    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic                  mem;
        logic [REG_ADDR_W-1:0] rd;
    } stage_ctl_t;

endpackage

// File: rtl/hazard_scoreboard_cmp.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_cmp
//   Compares one source register index against the destination registers
//   held by the three in-flight stages (s1, s2, s3).
//
//   Ports:
//     rs        in   source register index from s0
//     stage_s1  in   shadow entry of s1
//     stage_s2  in   shadow entry of s2
//     stage_s3  in   shadow entry of s3
//     hit       out  hit[0]=s1, hit[1]=s2, hit[2]=s3
//
//   A hit needs a valid stage that writes the register; x0 never matches.
// ---------------------------------------------------------------------------
module hazard_scoreboard_cmp
    import pipeline_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs,
    input  stage_ctl_t            stage_s1,
    input  stage_ctl_t            stage_s2,
    input  stage_ctl_t            stage_s3,
    output logic [2:0]            hit
);

    logic rs_nonzero;

    // The memory flags are carried in the entry but play no part in RAW checks.
    logic unused_mem;
    assign unused_mem = stage_s1.mem ^ stage_s2.mem ^ stage_s3.mem;

    always_comb begin
        rs_nonzero = |rs;
        hit        = '0;
        hit[0]     = stage_s1.valid & stage_s1.we & (stage_s1.rd == rs) & rs_nonzero;
        hit[1]     = stage_s2.valid & stage_s2.we & (stage_s2.rd == rs) & rs_nonzero;
        hit[2]     = stage_s3.valid & stage_s3.we & (stage_s3.rd == rs) & rs_nonzero;
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Sequences the 4-stage pipeline: RAW stall of s0 against a scoreboard of
//   in-flight writers, flush of s0 on a branch taken in s1, and arbitration
//   of the single memory port between fetch and the s2 data access.
//
//   Build option:
//     RF_WRITE_THROUGH_EN  when defined, the s3 comparison is left out of
//                          the hazard check because the register file
//                          forwards the s3 write to same-cycle reads.
//
//   Ports:
//     clk, rst                      clock, synchronous active-high reset
//     s0_valid                      s0 holds a real instruction
//     s0_check_rs1/s0_check_rs2     microcode dependency-check bits
//     s0_rs1/s0_rs2/s0_rd           s0 register indices
//     s0_reg_write/s0_mem_in_use    microcode write-back / memory bits
//     s1_branch_taken               branch resolved taken in s1
//     fetch_req                     fetch unit wants the memory port
//     fetch_grant                   fetch owns the memory port this cycle
//     stall_s0                      hold PC/fetch/s0, bubble into s1
//     flush_s0                      kill s0 and the in-flight fetch
//     s1_valid/s2_valid/s3_valid    stage occupancy
//     s2_mem_grant                  s2 owns the memory port this cycle
//     stall_count/flush_count       wrapping cycle counters
//
//   Stage hand-off contract: s1..s3 never stall. s0 is accepted into s1 in
//   any cycle where s0_valid is high and neither stall_s0 nor flush_s0 is
//   asserted; otherwise s1 receives a bubble.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W     = 5,
    parameter int STAGES_TRACKED = 3,
    parameter int CNT_W          = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s0_valid,
    input  logic                  s0_check_rs1,
    input  logic                  s0_check_rs2,
    input  logic [REG_ADDR_W-1:0] s0_rs1,
    input  logic [REG_ADDR_W-1:0] s0_rs2,
    input  logic [REG_ADDR_W-1:0] s0_rd,
    input  logic                  s0_reg_write,
    input  logic                  s0_mem_in_use,
    input  logic                  s1_branch_taken,
    input  logic                  fetch_req,
    output logic                  fetch_grant,
    output logic                  stall_s0,
    output logic                  flush_s0,
    output logic                  s1_valid,
    output logic                  s2_valid,
    output logic                  s3_valid,
    output logic                  s2_mem_grant,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    import pipeline_pkg::*;

`ifdef RF_WRITE_THROUGH_EN
    localparam logic [STAGES_TRACKED-1:0] HIT_MASK = 3'b011;
`else
    localparam logic [STAGES_TRACKED-1:0] HIT_MASK = 3'b111;
`endif

    stage_ctl_t s1_q, s1_d;
    stage_ctl_t s2_q, s2_d;
    stage_ctl_t s3_q, s3_d;

    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    logic [STAGES_TRACKED-1:0] hit_rs1;
    logic [STAGES_TRACKED-1:0] hit_rs2;
    logic                      raw;

    hazard_scoreboard_cmp u_cmp_rs1 (
        .rs       (s0_rs1),
        .stage_s1 (s1_q),
        .stage_s2 (s2_q),
        .stage_s3 (s3_q),
        .hit      (hit_rs1)
    );

    hazard_scoreboard_cmp u_cmp_rs2 (
        .rs       (s0_rs2),
        .stage_s1 (s1_q),
        .stage_s2 (s2_q),
        .stage_s3 (s3_q),
        .hit      (hit_rs2)
    );

`ifdef RF_WRITE_THROUGH_EN
    logic unused_hit_s3;
    assign unused_hit_s3 = hit_rs1[2] ^ hit_rs2[2];
`endif

    always_comb begin
        // Flush wins over stall: the s0 instruction is discarded, not held.
        flush_s0     = s1_q.valid & s1_branch_taken;
        raw          = s0_valid &
                       ((s0_check_rs1 & (|(hit_rs1 & HIT_MASK))) |
                        (s0_check_rs2 & (|(hit_rs2 & HIT_MASK))));
        stall_s0     = raw & ~flush_s0;

        // The data access in s2 always beats fetch for the port.
        s2_mem_grant = s2_q.valid & s2_q.mem;
        fetch_grant  = fetch_req & ~s2_mem_grant & ~flush_s0;

        // A bubble carries we=0, so a stalled instruction cannot block itself.
        s1_d = '0;
        if (s0_valid && !stall_s0 && !flush_s0) begin
            s1_d.valid = 1'b1;
            s1_d.we    = s0_reg_write;
            s1_d.mem   = s0_mem_in_use;
            s1_d.rd    = s0_rd;
        end
        s2_d = s1_q;
        s3_d = s2_q;

        stall_count_d = stall_count_q + {{(CNT_W-1){1'b0}}, stall_s0};
        flush_count_d = flush_count_q + {{(CNT_W-1){1'b0}}, flush_s0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q          <= '0;
            s2_q          <= '0;
            s3_q          <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            s3_q          <= s3_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign s1_valid    = s1_q.valid;
    assign s2_valid    = s2_q.valid;
    assign s3_valid    = s3_q.valid;
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//   Table of per-cycle vectors (inputs plus hand-computed outputs) applied in
//   order, followed by a hand-written reset-while-busy sequence.
//   Inputs change 1 time unit after the rising edge; outputs are sampled on
//   the falling edge.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

`ifdef RF_WRITE_THROUGH_EN
    localparam bit WT = 1'b1;
`else
    localparam bit WT = 1'b0;
`endif
    // Stall counter after the back-to-back test, and after the multi-match test.
    localparam int SC2 = WT ? 2 : 3;
    localparam int SCM = WT ? SC2 + 2 : SC2 + 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        s0_valid, s0_check_rs1, s0_check_rs2;
    logic [4:0]  s0_rs1, s0_rs2, s0_rd;
    logic        s0_reg_write, s0_mem_in_use;
    logic        s1_branch_taken, fetch_req;
    logic        fetch_grant, stall_s0, flush_s0;
    logic        s1_valid, s2_valid, s3_valid, s2_mem_grant;
    logic [31:0] stall_count, flush_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REG_ADDR_W     (5),
        .STAGES_TRACKED (3),
        .CNT_W          (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .s0_valid        (s0_valid),
        .s0_check_rs1    (s0_check_rs1),
        .s0_check_rs2    (s0_check_rs2),
        .s0_rs1          (s0_rs1),
        .s0_rs2          (s0_rs2),
        .s0_rd           (s0_rd),
        .s0_reg_write    (s0_reg_write),
        .s0_mem_in_use   (s0_mem_in_use),
        .s1_branch_taken (s1_branch_taken),
        .fetch_req       (fetch_req),
        .fetch_grant     (fetch_grant),
        .stall_s0        (stall_s0),
        .flush_s0        (flush_s0),
        .s1_valid        (s1_valid),
        .s2_valid        (s2_valid),
        .s3_valid        (s3_valid),
        .s2_mem_grant    (s2_mem_grant),
        .stall_count     (stall_count),
        .flush_count     (flush_count)
    );

    typedef struct {
        bit         chk;
        bit         rst;
        bit         s0v;
        bit         c1;
        bit         c2;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        bit         we;
        bit         mem;
        bit         br;
        bit         freq;
        bit         e_fg;
        bit         e_stall;
        bit         e_flush;
        logic [2:0] e_v;      // {s3_valid, s2_valid, s1_valid}
        bit         e_mg;
        int         e_sc;
        int         e_fc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit chk, input bit r, input bit s0v, input bit c1, input bit c2,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input bit we, input bit mem, input bit br, input bit freq,
                       input bit e_fg, input bit e_stall, input bit e_flush,
                       input logic [2:0] e_v, input bit e_mg, input int e_sc, input int e_fc);
        vec_t v;
        v.chk = chk; v.rst = r; v.s0v = s0v; v.c1 = c1; v.c2 = c2;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.we = we; v.mem = mem;
        v.br = br; v.freq = freq;
        v.e_fg = e_fg; v.e_stall = e_stall; v.e_flush = e_flush;
        v.e_v = e_v; v.e_mg = e_mg; v.e_sc = e_sc; v.e_fc = e_fc;
        vecs.push_back(v);
    endtask

    // Idle cycle (no s0 instruction, no branch).
    task automatic idle(input bit freq, input bit e_fg, input logic [2:0] e_v,
                        input bit e_mg, input int e_sc, input int e_fc);
        add(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, freq, e_fg, 0, 0, e_v, e_mg, e_sc, e_fc);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic drive_s0(input bit s0v, input bit c1, input bit c2, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [4:0] rd, input bit we,
                            input bit mem);
        s0_valid = s0v; s0_check_rs1 = c1; s0_check_rs2 = c2;
        s0_rs1 = rs1; s0_rs2 = rs2; s0_rd = rd; s0_reg_write = we; s0_mem_in_use = mem;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input int idx, input vec_t v);
        rst = v.rst;
        drive_s0(v.s0v, v.c1, v.c2, v.rs1, v.rs2, v.rd, v.we, v.mem);
        s1_branch_taken = v.br;
        fetch_req = v.freq;
        @(negedge clk);
        if (v.chk) begin
            check("fetch_grant",  idx, {31'd0, fetch_grant},  {31'd0, v.e_fg});
            check("stall_s0",     idx, {31'd0, stall_s0},     {31'd0, v.e_stall});
            check("flush_s0",     idx, {31'd0, flush_s0},     {31'd0, v.e_flush});
            check("stage_valid",  idx, {29'd0, s3_valid, s2_valid, s1_valid}, {29'd0, v.e_v});
            check("s2_mem_grant", idx, {31'd0, s2_mem_grant}, {31'd0, v.e_mg});
            check("stall_count",  idx, stall_count, v.e_sc);
            check("flush_count",  idx, flush_count, v.e_fc);
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // ---- test 1: reset state, fetch_grant follows fetch_req ----
        add(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 0, 3'b000, 0, 0, 0);
        idle(1, 1, 3'b000, 0, 0, 0);
        idle(0, 0, 3'b000, 0, 0, 0);

        // ---- test 2: writer x5 then dependent on x5 right behind it ----
        add(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd5, 1, 0, 0, 1, 1, 0, 0, 3'b000, 0, 0, 0);
        add(1, 0, 1, 1, 0, 5'd5, 5'd0, 5'd6, 0, 0, 0, 1, 1, 1, 0, 3'b001, 0, 0, 0);
        add(1, 0, 1, 1, 0, 5'd5, 5'd0, 5'd6, 0, 0, 0, 1, 1, 1, 0, 3'b010, 0, 1, 0);
        add(1, 0, 1, 1, 0, 5'd5, 5'd0, 5'd6, 0, 0, 0, 1, 1, !WT, 0, 3'b100, 0, 2, 0);
`ifndef RF_WRITE_THROUGH_EN
        add(1, 0, 1, 1, 0, 5'd5, 5'd0, 5'd6, 0, 0, 0, 1, 1, 0, 0, 3'b000, 0, 3, 0);
`endif
        idle(1, 1, 3'b001, 0, SC2, 0);
        idle(1, 1, 3'b010, 0, SC2, 0);
        idle(1, 1, 3'b100, 0, SC2, 0);
        idle(1, 1, 3'b000, 0, SC2, 0);

        // ---- test 3: writer to x0 then dependent on x0: never a hazard ----
        add(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 1, 1, 0, 0, 3'b000, 0, SC2, 0);
        add(1, 0, 1, 1, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 0, 0, 3'b001, 0, SC2, 0);
        idle(1, 1, 3'b011, 0, SC2, 0);
        idle(1, 1, 3'b110, 0, SC2, 0);
        idle(1, 1, 3'b100, 0, SC2, 0);

        // ---- test 4: load reaches s2 and takes the memory port for one cycle ----
        add(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd7, 1, 1, 0, 1, 1, 0, 0, 3'b000, 0, SC2, 0);
        idle(1, 1, 3'b001, 0, SC2, 0);
        idle(1, 0, 3'b010, 1, SC2, 0);
        idle(1, 1, 3'b100, 0, SC2, 0);
        idle(1, 1, 3'b000, 0, SC2, 0);

        // ---- multi-stage match: two writers of x9, dependent via rs2 ----
        add(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd9, 1, 0, 0, 0, 0, 0, 0, 3'b000, 0, SC2, 0);
        add(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd9, 1, 0, 0, 0, 0, 0, 0, 3'b001, 0, SC2, 0);
        add(1, 0, 1, 1, 1, 5'd3, 5'd9, 5'd11, 0, 0, 0, 0, 0, 1, 0, 3'b011, 0, SC2, 0);
        add(1, 0, 1, 1, 1, 5'd3, 5'd9, 5'd11, 0, 0, 0, 0, 0, 1, 0, 3'b110, 0, SC2 + 1, 0);
        add(1, 0, 1, 1, 1, 5'd3, 5'd9, 5'd11, 0, 0, 0, 0, 0, !WT, 0, 3'b100, 0, SC2 + 2, 0);
        add(1, 0, 1, 1, 1, 5'd3, 5'd9, 5'd11, 0, 0, 0, 0, 0, 0, 0, WT ? 3'b001 : 3'b000, 0, SCM, 0);
        idle(0, 0, WT ? 3'b011 : 3'b001, 0, SCM, 0);
        idle(0, 0, WT ? 3'b110 : 3'b010, 0, SCM, 0);
        idle(0, 0, 3'b100, 0, SCM, 0);
        idle(0, 0, 3'b000, 0, SCM, 0);

        // ---- test 5: dependent in s0 while branch resolves taken in s1 ----
        add(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd10, 1, 0, 0, 1, 1, 0, 0, 3'b000, 0, SCM, 0);
        add(1, 0, 1, 1, 0, 5'd10, 5'd0, 5'd0, 0, 0, 1, 1, 0, 0, 1, 3'b001, 0, SCM, 0);
        idle(1, 1, 3'b010, 0, SCM, 1);
        idle(1, 1, 3'b100, 0, SCM, 1);
        idle(1, 1, 3'b000, 0, SCM, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(i, vecs[i]);
        end

        // ---- test 6: reset while three writers of x12 are in flight ----
        rst = 1'b0;
        s1_branch_taken = 1'b0;
        fetch_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_s0(1, 0, 0, 5'd0, 5'd0, 5'd12, 1, 0);
            step();
        end
        drive_s0(0, 1, 0, 5'd12, 5'd0, 5'd0, 0, 0);
        @(negedge clk);
        check("t6_valid_full", 100, {29'd0, s3_valid, s2_valid, s1_valid}, 32'd7);
        check("t6_nostall_s0_invalid", 100, {31'd0, stall_s0}, 32'd0);
        drive_s0(1, 1, 0, 5'd12, 5'd0, 5'd0, 0, 0);
        #1;
        check("t6_stall_before_rst", 101, {31'd0, stall_s0}, 32'd1);
        check("t6_stall_count_before_rst", 101, stall_count, SCM);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("t6_valid_after_rst", 102, {29'd0, s3_valid, s2_valid, s1_valid}, 32'd0);
        check("t6_stall_after_rst", 102, {31'd0, stall_s0}, 32'd0);
        check("t6_stall_count_rst", 102, stall_count, 32'd0);
        check("t6_flush_count_rst", 102, flush_count, 32'd0);
        check("t6_fetch_grant_rst", 102, {31'd0, fetch_grant}, 32'd1);
        step();
        @(negedge clk);
        check("t6_dep_issued", 103, {29'd0, s3_valid, s2_valid, s1_valid}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
